// File: rtl/serial_pkg.sv
// Shared types and line-level constants for the serial transmitter.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT clocks per bit and emits a registered
// bit_tick during the last clock of each bit period.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  output logic bit_tick
);

  localparam int            CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // tick_q mirrors "current count is the last of the bit", so the FSM sees it
  // in the final cycle and moves on exactly at the bit boundary.
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (start) begin
      cnt_d  = '0;
      tick_d = (LAST == '0);
    end else if (en) begin
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      tick_d = (cnt_d == LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign bit_tick = tick_q;

endmodule

// File: rtl/serial_tx.sv
// Framed LSB-first serial transmitter (start, DATA_W data bits, stop).
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy
);

  localparam int            BW       = $clog2(DATA_W) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              tx_out_q, tx_out_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              xfer, bit_tick;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign xfer = (state_q == IDLE) && tx_valid;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (xfer),
    .en      (state_q != IDLE),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_out_d  = tx_out_q;
    busy_d    = busy_q;
    ready_d   = ready_q;
`ifdef SERIAL_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_out_d = LINE_IDLE;
        if (xfer) begin
          state_d   = START;
          shift_d   = tx_data;
          bit_cnt_d = '0;
          tx_out_d  = START_BIT;
          busy_d    = 1'b1;
          ready_d   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
          parity_d  = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_tick) begin
          state_d  = DATA;
          tx_out_d = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d  = PARITY;
            tx_out_d = parity_q;
`else
            state_d  = STOP;
            tx_out_d = STOP_BIT;
`endif
          end else begin
            tx_out_d = shift_d[0];
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_d  = STOP;
          tx_out_d = STOP_BIT;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          state_d  = IDLE;
          tx_out_d = LINE_IDLE;
          busy_d   = 1'b0;
          ready_d  = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        tx_out_d = LINE_IDLE;
        busy_d   = 1'b0;
        ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_out_q  <= LINE_IDLE;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx_out   = tx_out_q;
  assign busy     = busy_q;
  assign tx_ready = ready_q;

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Serial line transmitter: accepts a parallel word through a valid/ready handshake and shifts it out LSB-first as a framed bit stream (start bit, data bits, stop bit).
- Each bit is held for a programmable number of clocks.
- It drives the serial input of the team's bit-capture flops and receivers: it produces the single-bit `d` stream those flops sample.
- Idle line level is 1, matching preset semantics.

Parameters:
- DATA_W, 8, data bits per frame (1..32)
- CLKS_PER_BIT, 4, clock cycles each bit is held on tx_out (>=1)

Ports:
- clk  input  1  single rising-edge clock
- rst  input  1  asynchronous reset, active-high; no other reset exists
- tx_data  input  DATA_W  parallel word; sampled only on handshake
- tx_valid  input  1  producer has a word
- tx_ready  output  1  block can accept a word
- tx_out  output  1  serial line, registered
- busy  output  1  frame in progress

Behaviour:
- Reset (async, active-high):
  - tx_out=1, tx_ready=1, busy=0; state=IDLE; bit and clock counters cleared.
  - Reset mid-frame aborts the frame immediately; line returns to 1 without waiting for a clock; the word is lost.
- States: IDLE, START, DATA, STOP (plus PARITY under the optional feature).
- Handshake:
  - Transfer occurs on the posedge where tx_valid=1 and tx_ready=1.
  - tx_ready=1 only in IDLE.
  - tx_data is latched into the shift register at transfer; later changes are ignored.
  - tx_valid with tx_ready=0 is held off; no word is dropped or queued.
- IDLE -> START on transfer. From the next cycle: tx_out=0 and busy=1.
- START: hold 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx_out = shift_reg[0], held for CLKS_PER_BIT cycles.
  - Then shift right and increment the bit counter.
  - After DATA_W bits, go to STOP.
- STOP: hold tx_out=1 for CLKS_PER_BIT cycles, then go to IDLE with tx_ready=1 and busy=0.
- Frame length: (DATA_W+2)*CLKS_PER_BIT cycles from the cycle after transfer.
- Back-to-back frames:
  - The earliest next transfer is the first IDLE cycle.
  - The next start bit then begins one cycle later, so there is minimum 1 idle-high cycle between frames.
- Counters:
  - Clock counter is width $clog2(CLKS_PER_BIT)+1 and counts 0..CLKS_PER_BIT-1, wrapping to 0 at each bit boundary.
  - Bit counter is width $clog2(DATA_W)+1.
- CLKS_PER_BIT=1: one bit per clock; no extra dead cycles.
- tx_out is a register output, never combinational from inputs.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- With the macro defined:
  - A PARITY state is inserted between DATA and STOP.
  - It transmits the even-parity bit (XOR of all DATA_W bits) for CLKS_PER_BIT cycles.
  - Frame becomes (DATA_W+3)*CLKS_PER_BIT cycles.
- Without the macro: no PARITY state, no parity logic, frame as above.

Decomposition:
- Shared package serial_pkg holds:
  - state enum tx_state_t (IDLE, START, DATA, PARITY, STOP)
  - constants LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1
- One sub-module is natural: bit_timer. It contains the CLKS_PER_BIT clock counter with async active-high reset and a registered bit_tick pulse. The FSM advances only on bit_tick.

Test Plan:
- Reset value: assert rst between edges -> tx_out=1, tx_ready=1, busy=0 immediately, before any posedge.
- Basic frame: DATA_W=8, CLKS_PER_BIT=4, send 0xA5.
  - tx_out = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 each 4 cycles, then 1 for 4 cycles.
  - tx_ready returns to 1 exactly 40 cycles after transfer.
- Backpressure: hold tx_valid=1 with 0x3C during the 0xA5 frame -> 0x3C is not accepted until the first IDLE cycle, then framed correctly; tx_data changes mid-frame do not alter 0xA5 bits.
- Reset mid-frame: assert rst during data bit 3 -> tx_out=1 asynchronously. A new word 0x0F after release yields a clean full frame.
- Edge parameter: CLKS_PER_BIT=1, send 0x01 -> tx_out sequence 0,1,0,0,0,0,0,0,0,1 on consecutive cycles.
- Parity (SERIAL_TX_PARITY_EN): send 0xA5 -> parity bit 0. Send 0x07 -> parity bit 1. Frame length is 44 cycles at CLKS_PER_BIT=4.
